// File: rtl/tl_tick_gen.sv
// GO tick timebase for the four-way traffic-light controller, with
// debounced PAUSE (freeze toggle) and STEP (single tick while frozen) buttons.
module tl_tick_gen #(
  parameter int unsigned DIV       = 50,
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned CW        = $clog2(DIV)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          PAUSE_BTN,
  input  logic          STEP_BTN,
  output logic          GO,
  output logic          PAUSED,
  output logic [CW-1:0] PRESC
);

  localparam int unsigned NBTN    = 2;
  localparam int unsigned DBW     = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
  localparam logic [CW-1:0]  P_LAST  = CW'(DIV - 1);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_PAUSED = 1'b1
  } state_t;

  state_t              state;
  logic [CW-1:0]       p;
  logic                go_q;
  logic [NBTN-1:0]     btn;
  logic [NBTN-1:0]     s1;
  logic [NBTN-1:0]     s2;
  logic [NBTN-1:0]     db;
  logic [NBTN-1:0]     db_d;
  logic [NBTN-1:0]     press;
  logic [DBW-1:0]      cnt [NBTN];
  logic                pause_press;
  logic                step_press;

  assign btn         = {STEP_BTN, PAUSE_BTN};
  assign press       = db & ~db_d;
  assign pause_press = press[0];
  assign step_press  = press[1];

  // Two-flop synchroniser, then a level debouncer that needs DB_CYCLES stable samples.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1   <= '0;
      s2   <= '0;
      db   <= '0;
      db_d <= '0;
      for (int i = 0; i < NBTN; i++) cnt[i] <= '0;
    end else begin
      s1   <= btn;
      s2   <= s1;
      db_d <= db;
      for (int i = 0; i < NBTN; i++) begin
        if (s2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          db[i]  <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + DBW'(1);
        end
      end
    end
  end

  // Prescaler and run/pause FSM; a pause press always wins over a step press.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= ST_RUN;
      p     <= '0;
      go_q  <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (pause_press) begin
            state <= ST_PAUSED;
            go_q  <= 1'b0;
          end else if (p == P_LAST) begin
            p    <= '0;
            go_q <= 1'b1;
          end else begin
            p    <= p + CW'(1);
            go_q <= 1'b0;
          end
        end
        ST_PAUSED: begin
          if (pause_press) begin
            // Resume from the held count; a withheld wrap tick fires now.
            state <= ST_RUN;
            if (p == P_LAST) begin
              p    <= '0;
              go_q <= 1'b1;
            end else begin
              p    <= p + CW'(1);
              go_q <= 1'b0;
            end
          end else begin
            go_q <= step_press;
          end
        end
        default: begin
          state <= ST_RUN;
          go_q  <= 1'b0;
        end
      endcase
    end
  end

  assign GO     = go_q;
  assign PAUSED = (state == ST_PAUSED);
  assign PRESC  = p;

endmodule

// File: tb/tb_tl_tick_gen.sv
// Directed bench for tl_tick_gen with DIV=5, DB_CYCLES=4; edge numbers count
// rising CLK edges after reset release, inputs change 1 ns after an edge.
`timescale 1ns/100ps
module tb_tl_tick_gen;

  localparam int unsigned DIV = 5;
  localparam int unsigned DBC = 4;
  localparam int unsigned CW  = $clog2(DIV);

  logic          CLK = 1'b0;
  logic          RST;
  logic          PAUSE_BTN;
  logic          STEP_BTN;
  logic          GO;
  logic          PAUSED;
  logic [CW-1:0] PRESC;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int e        = 0;

  tl_tick_gen #(.DIV(DIV), .DB_CYCLES(DBC)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .PAUSE_BTN(PAUSE_BTN),
    .STEP_BTN (STEP_BTN),
    .GO       (GO),
    .PAUSED   (PAUSED),
    .PRESC    (PRESC)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
    e++;
  endtask

  task automatic test_reset();
    RST = 1'b0; PAUSE_BTN = 1'b0; STEP_BTN = 1'b0;
    #2;
    tot_cnt++;
    if ({GO, PAUSED, PRESC} !== {1'b0, 1'b0, CW'(0)})
      $display("FAIL reset_t2 got go=%b paused=%b presc=%0d exp 0/0/0", GO, PAUSED, PRESC);
    else pass_cnt++;
    @(posedge CLK); #1;
    tot_cnt++;
    if ({GO, PAUSED, PRESC} !== {1'b0, 1'b0, CW'(0)})
      $display("FAIL reset_held got go=%b paused=%b presc=%0d exp 0/0/0", GO, PAUSED, PRESC);
    else pass_cnt++;
    RST = 1'b1;
    e = 0;
  endtask

  task automatic test_free_run();
    logic [CW-1:0] ep;
    repeat (15) begin
      tick();
      ep = CW'(e % 5);
      tot_cnt++;
      if ({GO, PAUSED, PRESC} !== {(ep == 0), 1'b0, ep})
        $display("FAIL free_run e=%0d got go=%b paused=%b presc=%0d exp go=%b paused=0 presc=%0d",
                 e, GO, PAUSED, PRESC, (ep == 0), ep);
      else pass_cnt++;
    end
  endtask

  task automatic test_glitch();
    logic [CW-1:0] ep;
    PAUSE_BTN = 1'b1;
    while (e < 20) begin
      tick();
      if (e == 18) PAUSE_BTN = 1'b0;
      ep = CW'(e % 5);
      tot_cnt++;
      if ({GO, PAUSED, PRESC} !== {(ep == 0), 1'b0, ep})
        $display("FAIL glitch e=%0d got go=%b paused=%b presc=%0d exp go=%b paused=0 presc=%0d",
                 e, GO, PAUSED, PRESC, (ep == 0), ep);
      else pass_cnt++;
    end
  endtask

  task automatic test_pause_hold();
    logic [CW-1:0] ep;
    logic eg, eps;
    PAUSE_BTN = 1'b1;
    while (e < 50) begin
      tick();
      if (e == 40) PAUSE_BTN = 1'b0;
      if (e <= 26) begin ep = CW'(e % 5); eg = (ep == 0); eps = 1'b0; end
      else         begin ep = CW'(1);     eg = 1'b0;      eps = 1'b1; end
      tot_cnt++;
      if ({GO, PAUSED, PRESC} !== {eg, eps, ep})
        $display("FAIL pause_hold e=%0d got go=%b paused=%b presc=%0d exp go=%b paused=%b presc=%0d",
                 e, GO, PAUSED, PRESC, eg, eps, ep);
      else pass_cnt++;
    end
  endtask

  task automatic test_step();
    logic eg;
    STEP_BTN = 1'b1;
    while (e < 80) begin
      tick();
      if (e == 58) STEP_BTN = 1'b0;
      if (e == 65) STEP_BTN = 1'b1;
      if (e == 73) STEP_BTN = 1'b0;
      eg = (e == 57) || (e == 72);
      tot_cnt++;
      if ({GO, PAUSED, PRESC} !== {eg, 1'b1, CW'(1)})
        $display("FAIL step e=%0d got go=%b paused=%b presc=%0d exp go=%b paused=1 presc=1",
                 e, GO, PAUSED, PRESC, eg);
      else pass_cnt++;
    end
  endtask

  task automatic test_pause_at_wrap();
    logic [CW-1:0] ep;
    logic eg, eps;
    PAUSE_BTN = 1'b1;
    while (e < 122) begin
      tick();
      if (e == 84)  PAUSE_BTN = 1'b0;
      if (e == 93)  PAUSE_BTN = 1'b1;
      if (e == 97)  PAUSE_BTN = 1'b0;
      if (e == 110) PAUSE_BTN = 1'b1;
      if (e == 114) PAUSE_BTN = 1'b0;
      if (e <= 86)       begin ep = CW'(1);              eg = 1'b0;    eps = 1'b1; end
      else if (e <= 99)  begin ep = CW'((e - 85) % 5);   eg = (ep == 0); eps = 1'b0; end
      else if (e <= 116) begin ep = CW'(4);              eg = 1'b0;    eps = 1'b1; end
      else               begin ep = CW'((e - 117) % 5);  eg = (ep == 0); eps = 1'b0; end
      tot_cnt++;
      if ({GO, PAUSED, PRESC} !== {eg, eps, ep})
        $display("FAIL pause_wrap e=%0d got go=%b paused=%b presc=%0d exp go=%b paused=%b presc=%0d",
                 e, GO, PAUSED, PRESC, eg, eps, ep);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    logic [CW-1:0] ep;
    logic eg, eps;
    while (e < 140) begin
      tick();
      if (e == 125) PAUSE_BTN = 1'b1;
      if (e == 129) PAUSE_BTN = 1'b0;
      if (e == 136) STEP_BTN  = 1'b1;
      if (e <= 131) begin ep = CW'((e - 117) % 5); eg = (ep == 0); eps = 1'b0; end
      else          begin ep = CW'(4);             eg = 1'b0;      eps = 1'b1; end
      tot_cnt++;
      if ({GO, PAUSED, PRESC} !== {eg, eps, ep})
        $display("FAIL pre_reset e=%0d got go=%b paused=%b presc=%0d exp go=%b paused=%b presc=%0d",
                 e, GO, PAUSED, PRESC, eg, eps, ep);
      else pass_cnt++;
    end
    #2;
    RST = 1'b0;
    #0.5;
    tot_cnt++;
    if ({GO, PAUSED, PRESC} !== {1'b0, 1'b0, CW'(0)})
      $display("FAIL reset_mid got go=%b paused=%b presc=%0d exp 0/0/0", GO, PAUSED, PRESC);
    else pass_cnt++;
    STEP_BTN = 1'b0;
    #0.5;
    RST = 1'b1;
    e = 0;
    repeat (10) begin
      tick();
      ep = CW'(e % 5);
      tot_cnt++;
      if ({GO, PAUSED, PRESC} !== {(ep == 0), 1'b0, ep})
        $display("FAIL post_reset e=%0d got go=%b paused=%b presc=%0d exp go=%b paused=0 presc=%0d",
                 e, GO, PAUSED, PRESC, (ep == 0), ep);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_glitch();
    test_pause_hold();
    test_step();
    test_pause_at_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
